sdram_usb_dma: RTL and testbench
================================

SDRAM_USB_DMA -- requirements
Module: sdram_usb_dma

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word-address width.
REQ-002 Parameter LEN_W, default 16, packet-count width.
REQ-003 clk  in  1  memory-domain clock; same clock as the USB endpoint FIFOs' memory side.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; latches start_addr, len_pkts and dir_rd; ignored while busy.
REQ-006 dir_rd  in  1  1: SDRAM->USB (read); 0: USB->SDRAM (write).
REQ-007 start_addr  in  ADDR_W  first SDRAM word address.
REQ-008 len_pkts  in  LEN_W  transfer length in 32-word packets; 0 completes immediately.
REQ-009 abort  in  1  one-cycle pulse; terminates the current transfer.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse at completion or abort.
REQ-012 cmd_valid, cmd_ready, cmd_write  out/in/out  1 each  SDRAM command handshake; transfer on valid&&ready.
REQ-013 cmd_addr  out  ADDR_W; cmd_wdata  out  16  command address and write data.
REQ-014 rsp_valid  in  1; rsp_data  in  16  in-order read responses, one per read command.
REQ-015 fifo_wr_addr  out  5; fifo_wr_data  out  16; fifo_wr_en  out  1; fifo_wr_push  out  1; fifo_wr_full  in  1  packet-slot write port toward USB.
REQ-016 fifo_rd_data  in  16; fifo_rd_pull  out  1; fifo_rd_empty  in  1  first-word-fall-through stream from USB.

Function
REQ-017 States: IDLE, RD_WAIT, RD_ISSUE, RD_DRAIN, RD_PUSH, WR_RUN, DONE.
REQ-018 IDLE + start: len_pkts==0 -> DONE; dir_rd -> RD_WAIT; else WR_RUN.
REQ-019 RD_WAIT: fifo_wr_full low -> RD_ISSUE; cmd_valid low.
REQ-020 RD_ISSUE: 32 read commands at consecutive addresses; issued index 31 accepted -> RD_DRAIN.
REQ-021 Each rsp_valid writes rsp_data to fifo_wr_addr = response index (0..31) with fifo_wr_en in the same cycle, zero added latency.
REQ-022 Responses may arrive during RD_ISSUE; 32nd response -> RD_PUSH.
REQ-023 RD_PUSH: fifo_wr_push high exactly one cycle; remaining packets nonzero -> RD_WAIT, else DONE.
REQ-024 WR_RUN: cmd_valid = !fifo_rd_empty, cmd_write=1, cmd_wdata=fifo_rd_data; fifo_rd_pull = cmd_valid&&cmd_ready.
REQ-025 WR_RUN ends after 32*len_pkts words accepted -> DONE.
REQ-026 Address increments by 1 per accepted command, wraps modulo 2^ADDR_W.
REQ-027 Word counter LEN_W+5 bits; no overflow at len_pkts = 2^LEN_W-1.
REQ-028 cmd_valid, once high, holds with stable addr/data until accepted, except on abort.
REQ-029 DONE: done high one cycle, busy low, -> IDLE.
REQ-030 abort in read states: stop issuing; RD_DRAIN absorbs outstanding responses with fifo_wr_en low; no push; then DONE.
REQ-031 abort in WR_RUN: cmd_valid low next cycle; word accepted in the abort cycle completes; -> DONE.
REQ-032 start and abort together in IDLE: start ignored.

Reset
REQ-033 Reset: state IDLE; busy, done, cmd_valid, fifo_wr_en, fifo_wr_push, fifo_rd_pull low; counters and address zero.
REQ-034 Reset mid-transfer abandons it; no done pulse.

Configuration
REQ-035 Macro SDRAM_USB_DMA_STATS_EN defined: adds output stall_cycles[31:0], cleared on accepted start, incremented each busy cycle with cmd_valid&&!cmd_ready or in RD_WAIT; saturates at 2^32-1.
REQ-036 Macro undefined: no stall_cycles port, no counter logic.

Structure
REQ-037 Package sdram_usb_pkg holds the state enumeration, PKT_WORDS=32 and the LEN_W/ADDR_W defaults.
REQ-038 Sub-module sdram_usb_dma_cnt: address/word/response counter set, instantiated once.
REQ-039 Single clock domain; no synchronizers.

Verification
REQ-040 Read: start_addr=0x000100, len_pkts=2, zero-latency SDRAM model -> 64 reads 0x100..0x13F, two pushes, each slot addr 0..31 in order, one done.
REQ-041 Read backpressure: fifo_wr_full high 50 cycles before packet 2 -> no commands during the hold, second push after release.
REQ-042 Write: 32 words 0xA000..0xA01F, cmd_ready toggling every cycle -> 32 writes in order, addr 0x000010..0x00002F, 32 pulls.
REQ-043 Wrap: start_addr=0xFFFFF0, len_pkts=1, read -> addresses 0xFFFFF0..0xFFFFFF then 0x000000..0x00000F.
REQ-044 Abort in read after 10 accepted, 4 responses -> 6 responses absorbed, no push, done pulse, busy low.
REQ-045 len_pkts=0 -> done two cycles after start, no commands; async reset during WR_RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sdram_usb_pkg.sv
// Shared constants and state encoding for the SDRAM <-> USB packet DMA.
// A packet is PKT_WORDS 16-bit words; lengths are counted in packets.
package sdram_usb_pkg;

   localparam int PKT_WORDS  = 32;
   localparam int PKT_IDX_W  = 5;
   localparam int ADDR_W_DEF = 24;
   localparam int LEN_W_DEF  = 16;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD_WAIT  = 3'd1;
   localparam logic [2:0] ST_RD_ISSUE = 3'd2;
   localparam logic [2:0] ST_RD_DRAIN = 3'd3;
   localparam logic [2:0] ST_RD_PUSH  = 3'd4;
   localparam logic [2:0] ST_WR_RUN   = 3'd5;
   localparam logic [2:0] ST_DONE     = 3'd6;

   // States in which read responses are being collected into the packet slot.
   function automatic logic is_rd_collect(input logic [2:0] st);
      return (st == ST_RD_ISSUE) || (st == ST_RD_DRAIN);
   endfunction

endpackage

// File: rtl/sdram_usb_dma_cnt.sv
// Address / remaining-word / per-packet issue and response counters for sdram_usb_dma.
// All counters clear on reset and reload on an accepted start.
module sdram_usb_dma_cnt
   import sdram_usb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len_pkts,
   input  logic              cmd_hs,
   input  logic              rsp_hit,
   input  logic              pkt_clr,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W+4:0]  word_rem,
   output logic [5:0]        issue_cnt,
   output logic [5:0]        rsp_cnt
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W+4:0]  WORD_ONE = {{(LEN_W+4){1'b0}}, 1'b1};

   // The address wraps modulo 2^ADDR_W by plain truncation; word_rem is wide
   // enough for the largest packet count times 32 words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         word_rem <= '0;
      end else if (load) begin
         addr     <= start_addr;
         word_rem <= {len_pkts, {PKT_IDX_W{1'b0}}};
      end else if (cmd_hs) begin
         addr     <= addr + ADDR_ONE;
         word_rem <= word_rem - WORD_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         rsp_cnt   <= '0;
      end else if (load || pkt_clr) begin
         issue_cnt <= '0;
         rsp_cnt   <= '0;
      end else begin
         if (cmd_hs) begin
            issue_cnt <= issue_cnt + 6'd1;
         end
         if (rsp_hit) begin
            rsp_cnt <= rsp_cnt + 6'd1;
         end
      end
   end

endmodule

// File: rtl/sdram_usb_dma.sv
// Packet DMA between SDRAM and the USB endpoint FIFOs (read: SDRAM->USB, write: USB->SDRAM).
// Optional SDRAM_USB_DMA_STATS_EN adds a saturating stall_cycles counter output.
module sdram_usb_dma
   import sdram_usb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              dir_rd,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len_pkts,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [15:0]       cmd_wdata,
   input  logic              rsp_valid,
   input  logic [15:0]       rsp_data,
   output logic [4:0]        fifo_wr_addr,
   output logic [15:0]       fifo_wr_data,
   output logic              fifo_wr_en,
   output logic              fifo_wr_push,
   input  logic              fifo_wr_full,
   input  logic [15:0]       fifo_rd_data,
   output logic              fifo_rd_pull,
   input  logic              fifo_rd_empty,
   output logic [2:0]        state_dbg
`ifdef SDRAM_USB_DMA_STATS_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam logic [5:0] LAST_IDX = 6'(PKT_WORDS - 1);

   logic [2:0]        state_q, state_d;
   logic              aborting_q, aborting_d;
   logic              done_q;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W+4:0]  word_rem;
   logic [5:0]        issue_cnt;
   logic [5:0]        rsp_cnt;
   logic              load;
   logic              cmd_hs;
   logic              rsp_hit;
   logic              pkt_clr;

   sdram_usb_dma_cnt #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .start_addr (start_addr),
      .len_pkts   (len_pkts),
      .cmd_hs     (cmd_hs),
      .rsp_hit    (rsp_hit),
      .pkt_clr    (pkt_clr),
      .addr       (addr),
      .word_rem   (word_rem),
      .issue_cnt  (issue_cnt),
      .rsp_cnt    (rsp_cnt)
   );

   // Command handshake: a command transfers on the rising edge where
   // cmd_valid && cmd_ready; once raised, cmd_valid and cmd_addr/cmd_wdata stay
   // put until that edge (only an abort may withdraw it).
   always_comb begin
      cmd_valid = 1'b0;
      if (state_q == ST_RD_ISSUE) begin
         cmd_valid = !issue_cnt[5];
      end else if (state_q == ST_WR_RUN) begin
         cmd_valid = !fifo_rd_empty;
      end
   end

   assign cmd_write    = (state_q == ST_WR_RUN);
   assign cmd_addr     = addr;
   assign cmd_wdata    = fifo_rd_data;
   assign cmd_hs       = cmd_valid && cmd_ready;
   assign fifo_rd_pull = cmd_write && cmd_hs;

   // Responses land in the slot combinationally; once aborting they are only counted.
   assign rsp_hit      = rsp_valid && is_rd_collect(state_q);
   assign fifo_wr_en   = rsp_hit && !aborting_q && !abort;
   assign fifo_wr_addr = rsp_cnt[4:0];
   assign fifo_wr_data = rsp_data;
   assign fifo_wr_push = (state_q == ST_RD_PUSH);
   assign pkt_clr      = (state_q == ST_RD_PUSH);

   assign load      = (state_q == ST_IDLE) && start && !abort;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = done_q;
   assign state_dbg = state_q;

   always_comb begin
      state_d    = state_q;
      aborting_d = aborting_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               aborting_d = 1'b0;
               if (len_pkts == '0) begin
                  state_d = ST_DONE;
               end else if (dir_rd) begin
                  state_d = ST_RD_WAIT;
               end else begin
                  state_d = ST_WR_RUN;
               end
            end
         end
         ST_RD_WAIT: begin
            if (abort) begin
               state_d = ST_DONE;
            end else if (!fifo_wr_full) begin
               state_d = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            if (abort) begin
               aborting_d = 1'b1;
               state_d    = ST_RD_DRAIN;
            end else if (rsp_valid && (rsp_cnt == LAST_IDX)) begin
               state_d = ST_RD_PUSH;
            end else if (cmd_hs && (issue_cnt == LAST_IDX)) begin
               state_d = ST_RD_DRAIN;
            end
         end
         ST_RD_DRAIN: begin
            // While aborting, leave once every issued read has been answered.
            if (aborting_q) begin
               if (issue_cnt == rsp_cnt) begin
                  state_d = ST_DONE;
               end
            end else if (abort) begin
               aborting_d = 1'b1;
            end else if (rsp_valid && (rsp_cnt == LAST_IDX)) begin
               state_d = ST_RD_PUSH;
            end
         end
         ST_RD_PUSH: begin
            if (abort || (word_rem == '0)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_WR_RUN: begin
            if (abort || (cmd_hs && (word_rem == {{(LEN_W+4){1'b0}}, 1'b1}))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         aborting_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         aborting_q <= aborting_d;
         done_q     <= (state_q == ST_DONE);
      end
   end

`ifdef SDRAM_USB_DMA_STATS_EN
   logic stall_now;

   assign stall_now = busy && ((cmd_valid && !cmd_ready) || (state_q == ST_RD_WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (load) begin
         stall_cycles <= '0;
      end else if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_usb_dma.sv
// Directed/randomized bench for sdram_usb_dma with SDRAM, USB FIFO models and a queue scoreboard.
// Expected addresses and slot contents are derived arithmetically from the transfer request.
module tb_sdram_usb_dma;

   localparam int ADDR_W = 24;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, dir_rd, abort;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  len_pkts;
   logic              busy, done;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [15:0]       cmd_wdata;
   logic              rsp_valid;
   logic [15:0]       rsp_data;
   logic [4:0]        fifo_wr_addr;
   logic [15:0]       fifo_wr_data;
   logic              fifo_wr_en, fifo_wr_push, fifo_wr_full;
   logic [15:0]       fifo_rd_data;
   logic              fifo_rd_pull, fifo_rd_empty;
   logic [2:0]        state_dbg;
`ifdef SDRAM_USB_DMA_STATS_EN
   logic [31:0]       stall_cycles;
`endif

   sdram_usb_dma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .dir_rd (dir_rd),
      .start_addr (start_addr), .len_pkts (len_pkts), .abort (abort),
      .busy (busy), .done (done),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid), .rsp_data (rsp_data),
      .fifo_wr_addr (fifo_wr_addr), .fifo_wr_data (fifo_wr_data), .fifo_wr_en (fifo_wr_en),
      .fifo_wr_push (fifo_wr_push), .fifo_wr_full (fifo_wr_full),
      .fifo_rd_data (fifo_rd_data), .fifo_rd_pull (fifo_rd_pull), .fifo_rd_empty (fifo_rd_empty),
      .state_dbg (state_dbg)
`ifdef SDRAM_USB_DMA_STATS_EN
      , .stall_cycles (stall_cycles)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [ADDR_W-1:0] cmd_addr_q[$];
   logic [15:0]       wdata_q[$];
   logic [20:0]       slot_q[$];
   logic [15:0]       rq[$];
   logic [15:0]       usb_q[$];
   logic [ADDR_W-1:0] exp_q[$];
   int n_cmds, n_wr, rd_acc, rsp_sent, push_cnt, pull_cnt, done_cnt;
   int vectors, miscompares;
   int ready_mode, ready_limit, rsp_limit;
   bit rsp_gaps, pull_pend, pend, mon_en, hold_valid_seen;
   logic [ADDR_W-1:0] pend_addr;
   logic [15:0]       pend_wdata;

   function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ {a[23:16], 8'hA5};
   endfunction

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor (samples on falling edge) ----------------
   always @(negedge clk) begin
      if (mon_en && pend) begin
         chk("hold_valid", 40'(cmd_valid), 40'd1);
         chk("hold_addr", 40'(cmd_addr), 40'(pend_addr));
         if (cmd_write) chk("hold_wdata", 40'(cmd_wdata), 40'(pend_wdata));
      end
      pend       = rst_n && cmd_valid && !cmd_ready && !abort;
      pend_addr  = cmd_addr;
      pend_wdata = cmd_wdata;
      if (cmd_valid && cmd_ready) begin
         n_cmds++;
         cmd_addr_q.push_back(cmd_addr);
         if (cmd_write) begin
            n_wr++;
            wdata_q.push_back(cmd_wdata);
         end else begin
            rd_acc++;
            rq.push_back(mem_word(cmd_addr));
         end
      end
      if (fifo_wr_en) slot_q.push_back({fifo_wr_addr, fifo_wr_data});
      if (fifo_wr_push) push_cnt++;
      if (fifo_rd_pull) begin
         pull_cnt++;
         pull_pend = 1'b1;
      end
      if (done) done_cnt++;
      if (cmd_valid) hold_valid_seen = 1'b1;
   end

   // ---------------- SDRAM / USB FIFO models (drive after rising edge) ----------------
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       cmd_ready = 1'b1;
         1:       cmd_ready = !cmd_ready;
         2:       cmd_ready = ($urandom_range(0, 3) != 0);
         default: cmd_ready = (rd_acc < ready_limit);
      endcase
      if (pull_pend) begin
         if (usb_q.size() > 0) void'(usb_q.pop_front());
         pull_pend = 1'b0;
      end
      fifo_rd_empty = (usb_q.size() == 0);
      fifo_rd_data  = (usb_q.size() == 0) ? 16'h0 : usb_q[0];
      if (rq.size() > 0 && rsp_sent < rsp_limit && (!rsp_gaps || $urandom_range(0, 1) == 1)) begin
         rsp_valid = 1'b1;
         rsp_data  = rq.pop_front();
         rsp_sent++;
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = 16'h0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      cmd_addr_q.delete(); wdata_q.delete(); slot_q.delete(); rq.delete();
      n_cmds = 0; n_wr = 0; rd_acc = 0; rsp_sent = 0;
      push_cnt = 0; pull_cnt = 0; done_cnt = 0; hold_valid_seen = 1'b0;
   endtask

   task automatic do_start(input logic rd, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
      @(posedge clk); #1;
      dir_rd = rd; start_addr = a; len_pkts = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 40'(done_cnt != 0), 40'd1);
   endtask

   task automatic chk_reads(input string tag, input logic [ADDR_W-1:0] base, input int words);
      exp_q.delete();
      for (int i = 0; i < words; i++) exp_q.push_back(base + ADDR_W'(i));
      chk({tag, "_ncmd"}, 40'(cmd_addr_q.size()), 40'(words));
      chk({tag, "_nslot"}, 40'(slot_q.size()), 40'(words));
      for (int i = 0; i < words && i < cmd_addr_q.size() && i < slot_q.size(); i++) begin
         chk({tag, "_addr"}, 40'(cmd_addr_q[i]), 40'(exp_q[i]));
         chk({tag, "_slot"}, 40'(slot_q[i]), 40'({5'(i % 32), mem_word(exp_q[i])}));
      end
   endtask

   task automatic chk_writes(input string tag, input logic [ADDR_W-1:0] base,
                             input logic [15:0] d0, input int words);
      chk({tag, "_nwr"}, 40'(n_wr), 40'(words));
      chk({tag, "_npull"}, 40'(pull_cnt), 40'(words));
      for (int i = 0; i < words && i < cmd_addr_q.size() && i < wdata_q.size(); i++) begin
         chk({tag, "_addr"}, 40'(cmd_addr_q[i]), 40'(base + ADDR_W'(i)));
         chk({tag, "_data"}, 40'(wdata_q[i]), 40'(d0 + 16'(i)));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, snap;
      vectors = 0; miscompares = 0;
      start = 0; abort = 0; dir_rd = 0; start_addr = '0; len_pkts = '0;
      cmd_ready = 0; rsp_valid = 0; rsp_data = 0; fifo_wr_full = 0;
      fifo_rd_data = 0; fifo_rd_empty = 1;
      ready_mode = 0; ready_limit = 0; rsp_limit = 1000; rsp_gaps = 0;
      mon_en = 0; pull_pend = 0;
      clear_logs();
      rst_n = 0;
      #12;
      chk("rst_busy", 40'(busy), 40'd0);
      chk("rst_done", 40'(done), 40'd0);
      chk("rst_cmd_valid", 40'(cmd_valid), 40'd0);
      chk("rst_wr_push", 40'(fifo_wr_push), 40'd0);
      chk("rst_rd_pull", 40'(fifo_rd_pull), 40'd0);
      chk("rst_wr_en", 40'(fifo_wr_en), 40'd0);
      @(negedge clk); rst_n = 1; mon_en = 1;
      repeat (2) tick();

      // Two-packet read, always-ready SDRAM.
      clear_logs();
      do_start(1'b1, 24'h000100, 16'd2);
      tick();
      chk("rd_busy", 40'(busy), 40'd1);
      wait_done("rd_done", 1000);
      chk("rd_busy_end", 40'(busy), 40'd0);
      chk_reads("rd", 24'h000100, 64);
      chk("rd_push", 40'(push_cnt), 40'd2);
      repeat (3) tick();
      chk("rd_done_once", 40'(done_cnt), 40'd1);

      // Read with the USB slot full for 50 cycles before packet 2.
      clear_logs();
      do_start(1'b1, 24'h002000, 16'd2);
      n = 0;
      while (push_cnt == 0 && n < 500) begin tick(); n++; end
      chk("bp_first_push", 40'(push_cnt), 40'd1);
      fifo_wr_full = 1'b1;
      snap = n_cmds;
      tick();
      hold_valid_seen = 1'b0;
      repeat (49) tick();
      chk("bp_no_cmds", 40'(n_cmds), 40'(snap));
      chk("bp_no_valid", 40'(hold_valid_seen), 40'd0);
      chk("bp_push_held", 40'(push_cnt), 40'd1);
      chk("bp_busy", 40'(busy), 40'd1);
      fifo_wr_full = 1'b0;
      wait_done("bp_done", 1000);
      chk("bp_push", 40'(push_cnt), 40'd2);
      chk_reads("bp", 24'h002000, 64);
`ifdef SDRAM_USB_DMA_STATS_EN
      chk("bp_stall", 40'(stall_cycles >= 32'd50), 40'd1);
`endif

      // One-packet write, ready toggling every cycle.
      clear_logs();
      for (int i = 0; i < 32; i++) usb_q.push_back(16'hA000 + 16'(i));
      tick();
      ready_mode = 1;
      do_start(1'b0, 24'h000010, 16'd1);
      wait_done("wr_done", 1000);
      chk_writes("wr", 24'h000010, 16'hA000, 32);
      chk("wr_no_reads", 40'(rd_acc), 40'd0);
      tick();
      chk("wr_usb_empty", 40'(usb_q.size()), 40'd0);

      // Read across the top of the address space, random ready and response gaps.
      clear_logs();
      ready_mode = 2; rsp_gaps = 1;
      do_start(1'b1, 24'hFFFFF0, 16'd1);
      wait_done("wrap_done", 2000);
      chk_reads("wrap", 24'hFFFFF0, 32);
      chk("wrap_push", 40'(push_cnt), 40'd1);
      rsp_gaps = 0;

      // Abort a read after 10 accepted commands and 4 responses.
      clear_logs();
      ready_mode = 3; ready_limit = 10; rsp_limit = 4;
      do_start(1'b1, 24'h000300, 16'd1);
      n = 0;
      while (!(rd_acc == 10 && rsp_sent == 4) && n < 500) begin tick(); n++; end
      chk("ab_setup", 40'(rd_acc * 100 + rsp_sent), 40'd1004);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      rsp_limit = 1000;
      wait_done("ab_done", 500);
      chk("ab_rsp_absorbed", 40'(rsp_sent), 40'd10);
      chk("ab_busy", 40'(busy), 40'd0);
      chk("ab_nslot", 40'(slot_q.size()), 40'd4);
      for (int i = 0; i < 4 && i < slot_q.size(); i++)
         chk("ab_slot", 40'(slot_q[i]), 40'({5'(i), mem_word(24'h000300 + 24'(i))}));
      chk("ab_push", 40'(push_cnt), 40'd0);
      chk("ab_ncmd", 40'(n_cmds), 40'd10);
      ready_mode = 0;

      // Abort a write: the word accepted in the abort cycle still completes.
      clear_logs();
      for (int i = 0; i < 64; i++) usb_q.push_back(16'hB000 + 16'(i));
      tick();
      do_start(1'b0, 24'h000040, 16'd2);
      repeat (5) tick();
      @(posedge clk); #1 abort = 1'b1;
      snap = n_wr;
      @(posedge clk); #1 abort = 1'b0;
      tick();
      chk("wab_valid_low", 40'(cmd_valid), 40'd0);
      wait_done("wab_done", 100);
      chk_writes("wab", 24'h000040, 16'hB000, snap + 1);
      usb_q.delete();
      repeat (2) tick();

      // Zero-length transfer: done two cycles after start, no commands.
      clear_logs();
      do_start(1'b1, 24'h000500, 16'd0);
      tick();
      chk("z_done_early", 40'(done), 40'd0);
      chk("z_busy", 40'(busy), 40'd0);
      tick();
      chk("z_done", 40'(done), 40'd1);
      chk("z_ncmd", 40'(n_cmds), 40'd0);

      // start together with abort in IDLE is ignored.
      clear_logs();
      @(posedge clk); #1;
      dir_rd = 1; start_addr = 24'h000600; len_pkts = 16'd1; start = 1; abort = 1;
      @(posedge clk); #1 start = 0; abort = 0;
      tick();
      chk("sa_busy", 40'(busy), 40'd0);
      repeat (3) tick();
      chk("sa_done", 40'(done_cnt), 40'd0);
      chk("sa_ncmd", 40'(n_cmds), 40'd0);

      // Asynchronous reset in the middle of a write.
      clear_logs();
      for (int i = 0; i < 40; i++) usb_q.push_back(16'hC000 + 16'(i));
      tick();
      do_start(1'b0, 24'h000080, 16'd2);
      repeat (4) tick();
      chk("ar_busy_before", 40'(busy), 40'd1);
      mon_en = 0;
      #2 rst_n = 0;
      #1;
      chk("ar_cmd_valid", 40'(cmd_valid), 40'd0);
      chk("ar_busy", 40'(busy), 40'd0);
      chk("ar_rd_pull", 40'(fifo_rd_pull), 40'd0);
      chk("ar_done", 40'(done), 40'd0);
      chk("ar_wr_en", 40'(fifo_wr_en), 40'd0);
      chk("ar_wr_push", 40'(fifo_wr_push), 40'd0);
      usb_q.delete();
      done_cnt = 0;
      tick();
      rst_n = 1;
      repeat (5) tick();
      chk("ar_no_done", 40'(done_cnt), 40'd0);
      chk("ar_idle", 40'(busy), 40'd0);
      mon_en = 1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed no completion, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
